// File: rtl/clb_cfg_loader.sv
// -----------------------------------------------------------------------------
// clb_cfg_loader
//
// Serial configuration loader for a column of NUM_CLB logic blocks.
//
// Wire format, MSB first:
//     PREAMBLE (8 bits)
//     length   (8 bits, must equal NUM_CLB)
//     NUM_CLB frames, each 37 config bits followed by 1 parity bit.
//     The 38 bits of every frame must contain an odd number of ones.
//
// Each good frame is written into a shadow image. Frame 0 goes to CLB 0.
// After the last frame passes its parity check, the whole shadow is copied
// to CFG in one cycle, so the CLBs never see a half-loaded image.
//
// Config word layout, bit 36 down to 0:
//     [36:27] mux2..mux6 selects (2 bits each)
//     [26:11] 16-bit LUT memory
//     [10:9]  comboption
//     [8:3]   o2m1_0, o2m2_0, o2m3_0, o2m1_1, o2m2_1, o2m3_1
//     [2:1]   DQmux1, DQmux2
//     [0]     floporlatch
//
// Ports:
//     K      in   clock, rising edge
//     RST    in   synchronous reset, active-high
//     DIN    in   serial bitstream data, MSB first
//     DVAL   in   DIN is valid; the bit is consumed on an edge where DVAL=1
//     CFG    out  committed config; CLB i at [i*CFG_W +: CFG_W]
//     CFG_WE out  one-cycle pulse in the cycle CFG takes a new image
//     BUSY   out  a load is in progress (LEN, DATA or COMMIT)
//     DONE   out  the last load committed successfully
//     ERR    out  sticky error (bad length or bad parity); cleared by RST only
// -----------------------------------------------------------------------------
module clb_cfg_loader #(
    parameter int                NUM_CLB   = 4,
    parameter int                CFG_W     = 37,
    parameter logic [7:0]        PREAMBLE  = 8'hF2,
    parameter logic [CFG_W-1:0]  DEF_FRAME = 37'h15_0008_B038
) (
    input  logic                       K,
    input  logic                       RST,
    input  logic                       DIN,
    input  logic                       DVAL,
    output logic [NUM_CLB*CFG_W-1:0]   CFG,
    output logic                       CFG_WE,
    output logic                       BUSY,
    output logic                       DONE,
    output logic                       ERR
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN    = 3'd1,
        S_DATA   = 3'd2,
        S_COMMIT = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    // Wire frame length: payload plus one parity bit.
    localparam logic [5:0] LAST_BIT = 6'(CFG_W);
    localparam logic [7:0] LEN_VAL  = 8'(NUM_CLB);
    localparam logic [7:0] LAST_IDX = 8'(NUM_CLB - 1);

    state_t             state_q;
    // Only the 7 oldest bits are stored; the 8th is DIN itself, so a match
    // is seen on the very edge that accepts the last preamble bit.
    logic [6:0]         pre_q;
    logic [6:0]         len_q;
    logic [5:0]         bit_cnt_q;
    logic [7:0]         idx_q;
    // Payload bits of the frame in flight; the parity bit is never stored.
    logic [CFG_W-1:0]   frame_q;
    logic               cfg_we_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;

    logic               parity_ok;
    logic               frame_end;
    logic               shadow_we;
    logic               commit;

    // Decodes feeding the per-CLB registers below.
    always_comb begin
        parity_ok = 1'b0;
        frame_end = 1'b0;
        shadow_we = 1'b0;
        commit    = 1'b0;
        parity_ok = ^{frame_q, DIN};
        frame_end = (state_q == S_DATA) && DVAL && (bit_cnt_q == LAST_BIT);
        shadow_we = frame_end && parity_ok;
        commit    = (state_q == S_COMMIT);
    end

    // -------------------------------------------------------------------------
    // Control FSM with registered status outputs.
    // -------------------------------------------------------------------------
    always_ff @(posedge K) begin
        if (RST) begin
            state_q   <= S_IDLE;
            pre_q     <= '0;
            len_q     <= '0;
            bit_cnt_q <= '0;
            idx_q     <= '0;
            frame_q   <= '0;
            cfg_we_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            cfg_we_q <= 1'b0;
            case (state_q)
                // IDLE and DONE both hunt for the preamble; DONE keeps the
                // flag up until a new load actually starts.
                S_IDLE, S_DONE: begin
                    if (DVAL) begin
                        pre_q <= {pre_q[5:0], DIN};
                        if ({pre_q, DIN} == PREAMBLE) begin
                            state_q   <= S_LEN;
                            pre_q     <= '0;
                            bit_cnt_q <= '0;
                            busy_q    <= 1'b1;
                            done_q    <= 1'b0;
                        end
                    end
                end

                S_LEN: begin
                    if (DVAL) begin
                        len_q <= {len_q[5:0], DIN};
                        if (bit_cnt_q == 6'd7) begin
                            bit_cnt_q <= '0;
                            idx_q     <= '0;
                            if ({len_q, DIN} == LEN_VAL) begin
                                state_q <= S_DATA;
                            end else begin
                                state_q <= S_ERR;
                                busy_q  <= 1'b0;
                                err_q   <= 1'b1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 6'd1;
                        end
                    end
                end

                S_DATA: begin
                    if (DVAL) begin
                        frame_q <= {frame_q[CFG_W-2:0], DIN};
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_q <= '0;
                            if (!parity_ok) begin
                                state_q <= S_ERR;
                                busy_q  <= 1'b0;
                                err_q   <= 1'b1;
                            end else if (idx_q == LAST_IDX) begin
                                state_q <= S_COMMIT;
                            end else begin
                                idx_q <= idx_q + 8'd1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 6'd1;
                        end
                    end
                end

                // One cycle regardless of DVAL; the shadow copy happens in
                // the per-CLB registers on this same edge.
                S_COMMIT: begin
                    state_q  <= S_DONE;
                    cfg_we_q <= 1'b1;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    pre_q    <= '0;
                end

                // Absorbing until reset.
                default: begin
                    state_q <= S_ERR;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Per-CLB shadow and committed config registers.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CLB; gi++) begin : g_clb
            logic [CFG_W-1:0] shadow_q;
            logic [CFG_W-1:0] cfg_q;

            always_ff @(posedge K) begin
                if (RST) begin
                    shadow_q <= '0;
                    cfg_q    <= DEF_FRAME;
                end else begin
                    if (shadow_we && (idx_q == 8'(gi))) begin
                        shadow_q <= frame_q;
                    end
                    if (commit) begin
                        cfg_q <= shadow_q;
                    end
                end
            end

            assign CFG[gi*CFG_W +: CFG_W] = cfg_q;
        end
    endgenerate

    assign CFG_WE = cfg_we_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign ERR    = err_q;

endmodule

// File: doc/clb_cfg_loader.md
Name: clb_cfg_loader

Overview:
- Serial configuration loader for a column of NUM_CLB logic blocks.
- Consumes a framed bitstream (preamble, length, per-CLB frames with odd parity) and builds a shadow image of every CLB's configuration registers: mux selects, 16-bit LUT memory, combinational option, input-mux bits, DQ muxes and flop/latch select.
- Commits the image atomically to the CLB config bus, replacing the hard-coded initial-block configuration.

Parameters:
NUM_CLB, 4, number of CLB frames per load (1..255)
CFG_W, 37, config bits per CLB (fixed layout below; do not override)
PREAMBLE, 8'hF2, sync pattern preceding the length byte
DEF_FRAME, 37'h15_0008_B038, per-CLB config value after reset

Ports:
K  input  1  clock, rising edge
RST  input  1  synchronous reset, active-high
DIN  input  1  serial bitstream data, MSB first
DVAL  input  1  DIN is valid this cycle; bit consumed on edge when high
CFG  output  NUM_CLB*CFG_W  committed config; CLB i at [i*CFG_W +: CFG_W]
CFG_WE  output  1  one-cycle pulse when CFG changes
BUSY  output  1  load in progress (LEN, DATA, COMMIT)
DONE  output  1  last load committed successfully
ERR  output  1  sticky error; cleared only by RST

Behaviour:
- Frame field map, bit 36 down to 0:
  - [36:35] mux2select, [34:33] mux3select, [32:31] mux4select, [30:29] mux5select, [28:27] mux6select
  - [26:11] mem
  - [10:9] comboption
  - [8:3] o2m1_0, o2m2_0, o2m3_0, o2m1_1, o2m2_1, o2m3_1
  - [2:1] DQmux1, DQmux2
  - [0] floporlatch
- Wire frame: 37 config bits MSB first, then 1 parity bit = 38 bits. The total count of ones in the 38 bits must be odd.
- Reset (RST high at edge):
  - state IDLE; every CFG slice = DEF_FRAME
  - CFG_WE=0, BUSY=0, DONE=0, ERR=0
  - preamble shifter, counters and shadow cleared
  - Reset mid-load discards the partial image.
- Only edges with DVAL=1 advance shifters and counters. DVAL=0 cycles stall with no state change.
- FSM:
  - IDLE: 8-bit shifter of accepted bits. When the shifter, including the bit just accepted, equals PREAMBLE -> LEN. Overlapping patterns are allowed.
  - LEN: accept 8 bits MSB first. After the 8th bit: value == NUM_CLB -> DATA (frame idx 0, bit cnt 0); otherwise -> ERR.
  - DATA: shift bits into a 38-bit frame register. On the 38th bit, check parity.
    - Pass: write the 37-bit payload to shadow[idx]. If idx == NUM_CLB-1 -> COMMIT, else idx+1, bit cnt 0.
    - Fail: -> ERR.
  - COMMIT (one cycle): CFG <= shadow, CFG_WE=1 for exactly this cycle's result, DONE<=1 -> DONE. Ignores DVAL.
  - DONE: CFG held. Preamble detector is re-armed and is the only shifter active. Full PREAMBLE match -> LEN with DONE<=0; CFG keeps the old image until the next COMMIT.
  - ERR: absorbing until RST. CFG keeps the last committed image; CFG_WE never pulses.
- Latency: the edge that accepts the final parity bit enters COMMIT. The next edge updates CFG, raises DONE and drives CFG_WE high for one cycle.
- Frame 0 (first received) maps to CLB 0.
- BUSY = state in {LEN, DATA, COMMIT}. DONE and ERR are never both high.
- Outputs are registered; no combinational path from DIN/DVAL to any output.

Test Plan:
- Reset: hold RST 2 cycles -> every CFG slice = 37'h15_0008_B038; CFG_WE=0, BUSY=0, DONE=0, ERR=0.
- Good load, NUM_CLB=2, DVAL continuous:
  - stimulus: F2, 02, frame0 payload 37'h0 + parity 1, frame1 payload 37'h1F_FFFF_FFFF + parity 0
  - -> exactly one CFG_WE pulse one edge after the last bit
  - -> CFG[36:0]=0, CFG[73:37]=37'h1F_FFFF_FFFF, DONE=1
- Parity error: same stream with frame1 parity flipped -> ERR=1 after the 76th frame bit; CFG unchanged at DEF_FRAME; no CFG_WE; ERR persists until RST.
- Length mismatch: F2, then length 03 with NUM_CLB=2 -> ERR=1 after the 8th length bit; BUSY=0.
- DVAL gaps: good-load stream with DVAL low every other cycle plus 5-cycle gaps and DIN toggling while low -> same CFG result as continuous; commit one edge after the last valid bit.
- Reset and reload:
  - RST asserted during frame 1 -> DEF_FRAME restored, state IDLE; a fresh good stream then commits normally.
  - From DONE, a second good stream -> DONE drops at preamble match, old CFG held until the new commit.
